// File: rtl/imem_pkg.sv
// Shared types for the loadable instruction memory.
// Fetch FSM states and response fault codes.
package imem_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_RANGE    = 2'd2;

endpackage

// File: rtl/imem_byte_array.sv
// Byte-addressed program storage, one byte write port and a
// combinational little-endian 32-bit read at a word-aligned address.
module imem_byte_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = {
    mem[raddr | AW'(3)],
    mem[raddr | AW'(2)],
    mem[raddr | AW'(1)],
    mem[raddr]
  };

endmodule

// File: rtl/imem_fetch_unit.sv
// Loadable instruction memory with a registered valid/ready fetch
// port and misaligned/out-of-range fault reporting.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  input  logic              load_done,
  output logic              load_err,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [1:0]        rsp_fault,
  output logic              loaded
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 4);
  localparam logic [ADDR_W:0]   SIZE = (ADDR_W + 1)'(DEPTH);

  state_t      state;
  state_t      nxt;
  logic        in_load;
  logic        load_oob;
  logic        we;
  logic        accept;
  logic [1:0]  fault;
  logic [31:0] rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= nxt;
  end

  always_comb begin
    nxt     = state;
    in_load = 1'b0;
    loaded  = 1'b0;
    unique case (state)
      EMPTY: if (load_en) nxt = LOAD;
      LOAD: begin
        in_load = 1'b1;
        if (load_done) nxt = READY;
      end
      READY: begin
        loaded = 1'b1;
        if (load_en) nxt = LOAD;
      end
      default: nxt = EMPTY;
    endcase
  end

  // Widened compare so a DEPTH equal to 2**ADDR_W cannot wrap to 0.
  assign load_oob = {1'b0, load_addr} >= SIZE;
  assign we       = in_load && load_we && !load_oob;

  assign fetch_ready = loaded && (!rsp_valid || rsp_ready) && !load_en;
  assign accept      = fetch_req && fetch_ready;

  always_comb begin
    fault = FAULT_NONE;
    if (fetch_pc[1:0] != 2'b00) fault = FAULT_MISALIGN;
    else if (fetch_pc > LAST)   fault = FAULT_RANGE;
  end

  imem_byte_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (load_addr[AW-1:0]),
    .wdata (load_data),
    .raddr (fetch_pc[AW-1:0] & ~AW'(3)),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_err <= 1'b0;
    end else if (state != LOAD && nxt == LOAD) begin
      load_err <= 1'b0;
    end else if (in_load && load_we && load_oob) begin
      load_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_fault <= FAULT_NONE;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_instr <= (fault == FAULT_NONE) ? rdata : 32'h0;
      rsp_fault <= fault;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: directed load/fetch vectors,
// responses checked by an independent monitor.
module tb_imem_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_en;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              load_done;
  logic              load_err;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_instr;
  logic [1:0]        rsp_fault;
  logic              loaded;

  int checks = 0;
  int fails  = 0;
  int w;
  logic [33:0] sb[$];

  imem_fetch_unit #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_done   (load_done),
    .load_err    (load_err),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_instr   (rsp_instr),
    .rsp_fault   (rsp_fault),
    .loaded      (loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wbyte(input logic [31:0] a, input logic [7:0] d,
                       input logic done);
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    load_done = done;
    tick();
    load_we   = 1'b0;
    load_done = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ei,
                       input logic [1:0] ef, output int waited);
    fetch_req = 1'b1;
    fetch_pc  = pc;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (fetch_ready) break;
      waited++;
      if (waited >= 20) break;
    end
    if (fetch_ready) begin
      sb.push_back({ef, ei});
    end else begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: pc %h got no accept, required accept", pc);
    end
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fetch_ready"}, 32'(fetch_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_instr"}, rsp_instr, 0);
    chk({tag, "_rsp_fault"}, 32'(rsp_fault), 0);
    chk({tag, "_load_err"}, 32'(load_err), 0);
    chk({tag, "_loaded"}, 32'(loaded), 0);
  endtask

  // Monitor: a response retires on the edge after a valid&&ready sample.
  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      logic [33:0] e;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: got %h/%0d required no response",
                 rsp_instr, rsp_fault);
      end else begin
        e = sb.pop_front();
        chk("rsp_instr", rsp_instr, e[31:0]);
        chk("rsp_fault", 32'(rsp_fault), 32'(e[33:32]));
      end
    end
  end

  initial begin
    reset     = 1'b0;
    load_en   = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    load_done = 1'b0;
    fetch_req = 1'b0;
    fetch_pc  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");

    // EMPTY: fetches are not accepted
    fetch_req = 1'b1;
    @(negedge clk);
    chk("empty_ready", 32'(fetch_ready), 0);
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    chk("empty_valid", 32'(rsp_valid), 0);

    tick();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    fetch_req = 1'b1;
    @(negedge clk);
    chk("load_ready", 32'(fetch_ready), 0);
    chk("load_loaded", 32'(loaded), 0);
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    chk("load_valid", 32'(rsp_valid), 0);

    wbyte(0, 8'h33, 0);
    wbyte(1, 8'h03, 0);
    wbyte(2, 8'h94, 0);
    wbyte(3, 8'h00, 0);
    wbyte(4, 8'hb3, 0);
    wbyte(5, 8'h03, 0);
    wbyte(6, 8'h39, 0);
    wbyte(7, 8'h41, 0);
    wbyte(252, 8'hef, 0);
    wbyte(253, 8'hbe, 0);
    wbyte(254, 8'had, 0);
    wbyte(255, 8'hde, 0);
    wbyte(256, 8'hff, 0);
    chk("load_err_set", 32'(load_err), 1);
    wbyte(8, 8'h11, 0);
    wbyte(9, 8'h22, 0);
    wbyte(10, 8'h33, 0);
    wbyte(11, 8'h44, 1);
    chk("ready_loaded", 32'(loaded), 1);
    chk("done_keeps_err", 32'(load_err), 1);

    // write+done together, then back-to-back fetches
    fetch(8, 32'h44332211, 2'd0, w);
    chk("first_ready_wait", w, 0);
    fetch(0, 32'h00940333, 2'd0, w);
    fetch(4, 32'h413903b3, 2'd0, w);
    chk("b2b_wait", w, 0);

    fetch(2, 32'h0, 2'd1, w);
    fetch(252, 32'hdeadbeef, 2'd0, w);
    fetch(256, 32'h0, 2'd2, w);
    fetch(32'hfffffffc, 32'h0, 2'd2, w);
    fetch(32'h103, 32'h0, 2'd1, w);
    tick();

    // backpressure: response must hold, no accept
    rsp_ready = 1'b0;
    fetch(0, 32'h00940333, 2'd0, w);
    fetch_req = 1'b1;
    fetch_pc  = 4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_instr", rsp_instr, 32'h00940333);
      chk("hold_ready", 32'(fetch_ready), 0);
      @(posedge clk);
    end
    #1 rsp_ready = 1'b1;
    fetch(4, 32'h413903b3, 2'd0, w);
    chk("release_wait", w, 0);
    tick();

    // reprogram with a response pending
    rsp_ready = 1'b0;
    fetch(0, 32'h00940333, 2'd0, w);
    load_en   = 1'b1;
    fetch_req = 1'b1;
    fetch_pc  = 4;
    @(negedge clk);
    chk("reload_ready", 32'(fetch_ready), 0);
    tick();
    load_en   = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("reload_err_clr", 32'(load_err), 0);
    chk("reload_loaded", 32'(loaded), 0);
    chk("reload_pending", 32'(rsp_valid), 1);
    tick();
    rsp_ready = 1'b1;
    tick();
    wbyte(0, 8'h13, 1);
    fetch(0, 32'h00940313, 2'd0, w);
    tick();

    // reset mid-load with a response pending
    rsp_ready = 1'b0;
    fetch(0, 32'h00940313, 2'd0, w);
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    wbyte(4, 8'h55, 0);
    reset = 1'b0;
    #1;
    sb.delete();
    chk_reset_outputs("midrst");
    tick();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    fetch(0, 32'h00940313, 2'd0, w);
    fetch(4, 32'h41390355, 2'd0, w);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
